// File: rtl/mux_pkg.sv
// mux_pkg: shared constants, occupancy encoding and select-range helper for the operand mux pipeline
package mux_pkg;
    localparam int MUX_MAX_N = 16;
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;
    function automatic logic sel_in_range(input logic [31:0] sel, input int unsigned n);
        return sel < n;
    endfunction
endpackage

// File: rtl/skid_buf.sv
// skid_buf: generic 2-entry valid/ready buffer; output register plus one skid entry for lossless back-pressure
module skid_buf
    import mux_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);
    occ_t r_occ, w_occ_nxt;
    logic [DW-1:0] r_out, r_skid;
    logic w_acc, w_pop;
    // Handshake flags decode only the occupancy register, so no input reaches them combinationally
    assign in_ready  = r_occ != OCC_FULL;
    assign out_valid = r_occ != OCC_EMPTY;
    assign out_data  = r_out;
    always_comb begin
        w_acc     = in_valid & in_ready;
        w_pop     = out_valid & out_ready;
        w_occ_nxt = r_occ;
        unique case (r_occ)
            OCC_EMPTY: w_occ_nxt = w_acc ? OCC_ONE : OCC_EMPTY;
            OCC_ONE:   w_occ_nxt = (w_acc && !w_pop) ? OCC_FULL : (w_pop && !w_acc) ? OCC_EMPTY : OCC_ONE;
            OCC_FULL:  w_occ_nxt = w_pop ? OCC_ONE : OCC_FULL;
            default:   w_occ_nxt = OCC_EMPTY;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_occ <= OCC_EMPTY;
        else       r_occ <= w_occ_nxt;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (r_occ == OCC_FULL && w_pop) r_out <= r_skid;
            else if (w_acc && (r_occ == OCC_EMPTY || w_pop)) r_out <= in_data;
            if (w_acc && r_occ == OCC_ONE && !w_pop) r_skid <= in_data;
        end
    end
endmodule

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-way operand mux with optional left-shift of the last input, registered through a skid buffer
module mux_n_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int N          = 4,
    parameter int SELW       = 2,
    parameter bit SHIFT_LAST = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_flat,
    input  logic [SELW-1:0]    sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err,
    input  logic               err_clr
);
    if (SELW != $clog2(N) || N < 2 || N > MUX_MAX_N) begin : g_bad_param
        $error("mux_n_pipe: N must be 2..16 and SELW must equal clog2(N)");
    end
    logic [WIDTH-1:0] w_in [N];
    for (genvar k = 0; k < N; k++) begin : g_in
        assign w_in[k] = in_flat[k*WIDTH +: WIDTH];
    end
    logic             w_ok, w_acc;
    logic [SELW-1:0]  w_idx;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH+SELW-1:0] w_buf_out;
    logic r_sel_err;
    // Out-of-range selects are clamped to index 0 before the array read, then forced to zero
    always_comb begin
        w_ok   = sel_in_range(32'(sel), N);
        w_idx  = w_ok ? sel : '0;
        w_word = !w_ok ? '0 :
                 (SHIFT_LAST && sel == SELW'(N-1)) ? {w_in[N-1][WIDTH-2:0], 1'b0} : w_in[w_idx];
        w_acc  = in_valid & in_ready;
    end
    skid_buf #(.DW(WIDTH+SELW)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_data   ({sel, w_word}),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (w_buf_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );
    assign out_sel  = w_buf_out[WIDTH +: SELW];
    assign out_data = w_buf_out[WIDTH-1:0];
    // A bad select accepted in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               r_sel_err <= 1'b0;
        else if (w_acc && !w_ok) r_sel_err <= 1'b1;
        else if (err_clr)        r_sel_err <= 1'b0;
    end
    assign sel_err = r_sel_err;
endmodule
